// File: rtl/mac_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_share_pkg
//  Description : Shared types, defaults and helpers for the shared
//                multiply-add scheduler (mac_share_ctrl / mac_share_pipe).
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_share_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Clamp an unsigned value to the largest number representable in width bits.
  function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_share_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_share_pipe
//  Description : Two-stage multiply-add (A*B, then +C) with a common enable.
//                Valid and requester id travel alongside the data.
//                MAC_SHARE_SAT_EN selects unsigned saturation at both stages;
//                otherwise both stages wrap modulo 2^W.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_share_pipe
  import mac_share_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           advance,
  input  logic           issue_valid,
  input  logic [W-1:0]   issue_a,
  input  logic [W-1:0]   issue_b,
  input  logic [W-1:0]   issue_c,
  input  logic [IDW-1:0] issue_id,
  output logic           v1,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic [IDW-1:0] res_id
);

  logic [W-1:0]   prod_q;
  logic [W-1:0]   c_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   prod_next;
  logic [W-1:0]   sum_next;

`ifdef MAC_SHARE_SAT_EN
  logic [2*W-1:0] full_prod;
  logic [W:0]     full_sum;
  assign full_prod = issue_a * issue_b;
  assign prod_next = W'(saturate(32'(full_prod), W));
  assign full_sum  = {1'b0, prod_q} + {1'b0, c_q};
  assign sum_next  = W'(saturate(32'(full_sum), W));
`else
  assign prod_next = issue_a * issue_b;
  assign sum_next  = prod_q + c_q;
`endif

  // Both stages move together on advance; in-flight data is discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      prod_q    <= '0;
      c_q       <= '0;
      id_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (advance) begin
      v1        <= issue_valid;
      prod_q    <= prod_next;
      c_q       <= issue_c;
      id_q      <= issue_id;
      res_valid <= v1;
      res_data  <= sum_next;
      res_id    <= id_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mac_share_ctrl
//  Description : Round-robin scheduler sharing one multiply-add pipeline
//                among N_REQ requesters; results return tagged with the
//                issuing requester's index, in grant order.
//                Build option MAC_SHARE_SAT_EN: saturating arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_share_ctrl
  import mac_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*W-1:0] req_c,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_data,
  output logic [IDW-1:0]     res_id,
  output logic               busy
);

  state_t         st;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           advance;
  logic           xfer;
  logic           v1;
  logic           v1_next;
  logic           res_valid_next;

  // The output stage can only be overwritten when it is empty or being retired.
  assign advance = !res_valid || res_ready;
  assign xfer    = grant_found && advance && !rst;

  // Occupancy the pipeline will have after this edge, used to detect draining.
  assign v1_next        = advance ? xfer : v1;
  assign res_valid_next = advance ? v1 : res_valid;

  assign busy = (st != IDLE);

  // First valid requester at or after rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Accept is one-hot on the granted requester, only when stage 1 can take it.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  // Pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Control state: idle, flowing, or output stalled by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: if (xfer) st <= RUN;
        RUN: begin
          if (res_valid && !res_ready)         st <= HOLD;
          else if (!v1_next && !res_valid_next) st <= IDLE;
        end
        HOLD: begin
          if (res_ready) st <= (!v1_next && !res_valid_next) ? IDLE : RUN;
        end
        default: st <= IDLE;
      endcase
    end
  end

  mac_share_pipe #(
    .W   (W),
    .IDW (IDW)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .issue_valid (xfer),
    .issue_a     (req_a[grant_idx*W +: W]),
    .issue_b     (req_b[grant_idx*W +: W]),
    .issue_c     (req_c[grant_idx*W +: W]),
    .issue_id    (grant_idx),
    .v1          (v1),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id)
  );

endmodule
`default_nettype wire

// File: tb/tb_mac_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_share_ctrl
//  Description : Directed self-checking bench for mac_share_ctrl (N_REQ=4,
//                W=8) with an in-order result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_share_ctrl;
  import mac_share_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           busy;

  int tests = 0;
  int fails = 0;
  bit auto_drop;

  logic [W-1:0] exp_q[$];
  logic [1:0]   expid_q[$];
  logic [1:0]   ret_ids[$];

  always #5 clk = ~clk;

  mac_share_ctrl #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    int p;
    int s;
    p = int'(a) * int'(b);
`ifdef MAC_SHARE_SAT_EN
    if (p > 255) p = 255;
    s = p + int'(c);
    if (s > 255) s = 255;
`else
    p = p % 256;
    s = (p + int'(c)) % 256;
`endif
    return W'(s);
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge, so what is
  // seen here is exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      expid_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        ret_ids.push_back(res_id);
        if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
        else begin
          check("sb_data", res_data, exp_q.pop_front());
          check("sb_id", res_id, expid_q.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(model(req_a[i*W +: W], req_b[i*W +: W], req_c[i*W +: W]));
          expid_q.push_back(2'(i));
        end
      end
    end
  end

  task automatic tick();
    logic [N-1:0] x;
    x = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~x;
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    res_ready = 1'b1;
    auto_drop = 1'b1;

    // Reset state, with all requesters asking during reset
    tick(); tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    req_valid = '0;
    rst       = 1'b0;
    #1;

    // Single request from requester 2: 3*5+7 = 22
    set_op(2, 8'd3, 8'd5, 8'd7);
    req_valid = 4'b0100;
    #1;
    check("single_grant", req_ready, 4'b0100);
    tick();
    check("single_lat1_valid", res_valid, 0);
    check("single_busy", busy, 1);
    tick();
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 22);
    check("single_id", res_id, 2);
    tick();
    check("single_retired", res_valid, 0);
    check("single_idle", busy, 0);

    // All four requesting continuously: a=i+1, b=2, c=i -> 3i+2
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 8'd2, W'(i));
    auto_drop = 1'b0;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", req_ready, 32'(1) << (k % 4));
      if (k >= 2) begin
        check("thru_valid", res_valid, 1);
        check("thru_id", res_id, (k - 2) % 4);
        check("thru_data", res_data, 3 * ((k - 2) % 4) + 2);
      end
      tick();
    end
    req_valid = '0;
    auto_drop = 1'b1;
    tick(); tick(); tick();
    check("thru_drained", busy, 0);

    // Overflow: 20*20+100
    set_op(0, 8'd20, 8'd20, 8'd100);
    req_valid = 4'b0001;
    tick();
    tick();
    check("ovf_valid", res_valid, 1);
`ifdef MAC_SHARE_SAT_EN
    check("ovf_data", res_data, 255);
`else
    check("ovf_data", res_data, 244);
`endif
    tick();

    // Backpressure: a=i+2, b=3, c=1 -> 7, 10, 13
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 2), 8'd3, 8'd1);
    res_ready = 1'b0;
    req_valid = 4'b0111;
    #1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_no_ready", req_ready, 0);
      check("bp_valid", res_valid, 1);
      check("bp_data_frozen", res_data, 7);
      check("bp_id_frozen", res_id, 0);
      tick();
    end
    check("bp_state_hold", 32'(dut.st), 32'(HOLD));
    check("bp_busy", busy, 1);
    ret_ids.delete();
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 10 && ret_ids.size() < 3; k++) tick();
    check("bp_retire_count", ret_ids.size(), 3);
    if (ret_ids.size() == 3) begin
      check("bp_order0", ret_ids[0], 0);
      check("bp_order1", ret_ids[1], 1);
      check("bp_order2", ret_ids[2], 2);
    end
    tick(); tick();
    check("bp_drained", busy, 0);

    // Reset with two operations in flight
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    tick();
    tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_res_valid", res_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_rr_ptr", dut.rr_ptr, 0);
    check("mid_v1", dut.v1, 0);
    rst       = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("mid_first_grant", req_ready, 4'b0010);
    tick(); tick(); tick(); tick();

    // Sparse requesters 1 and 3: grant order 1, 3, then wrap past 0 back to 1
    do_reset();
    auto_drop = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("sparse_g1", req_ready, 4'b0010);
    tick();
    check("sparse_g3", req_ready, 4'b1000);
    tick();
    check("sparse_ptr_wrap", dut.rr_ptr, 0);
    check("sparse_g1_again", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    auto_drop = 1'b1;
    tick(); tick(); tick();

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
